// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: PC register handshake, instruction-memory read port, flush and decode hand-off.
// The fetch controller uses the master modport; the PC/memory/decode side uses the slave modport.
interface fetch_ctrl_if;
    logic [31:0] pc;
    logic        pc_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign;

    modport master (
        input  pc, imem_ack, imem_data, flush, ready,
        output pc_write, imem_req, imem_addr, valid, instr, instr_pc, misalign
    );

    modport slave (
        output pc, imem_ack, imem_data, flush, ready,
        input  pc_write, imem_req, imem_addr, valid, instr, instr_pc, misalign
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read feeding a 2-entry {instr, pc} FIFO.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_ctrl (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    localparam logic [31:0] PC_SENTINEL = 32'hFFFF_FFFF;
    localparam int          DEPTH       = 2;

    state_t      state_reg;
    logic        pc_write_reg;
    logic        imem_req_reg;
    logic [31:0] imem_addr_reg;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;
    logic [1:0]  count_next;

    logic push;
    logic pop;
    logic can_issue;
    logic pc_is_sentinel;
    logic pc_misaligned;
    logic misalign_lock;
    logic do_issue;
    logic do_sentinel;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else if (can_issue && !pc_is_sentinel && pc_misaligned) begin
            misalign_reg <= 1'b1;
        end
    end

    assign pc_misaligned = (bus.pc[1:0] != 2'b00);
    assign misalign_lock = misalign_reg;
    assign bus.misalign  = misalign_reg;
`else
    assign pc_misaligned = 1'b0;
    assign misalign_lock = 1'b0;
    assign bus.misalign  = 1'b0;
`endif

    // While pc_write is high the PC input still shows the old value, so IDLE waits one cycle
    // for the PC register to load before acting on it again.
    always_comb begin
        push           = (state_reg == WAIT) && bus.imem_ack && !bus.flush;
        pop            = (count_reg != 2'd0) && bus.ready && !bus.flush;
        pc_is_sentinel = (bus.pc == PC_SENTINEL);
        can_issue      = (state_reg == IDLE) && !bus.flush && !pc_write_reg
                         && (count_reg < 2'(DEPTH)) && !misalign_lock;
        do_sentinel    = can_issue && pc_is_sentinel;
        do_issue       = can_issue && !pc_is_sentinel && !pc_misaligned;
    end

    always_comb begin
        count_next = count_reg;
        if (bus.flush) begin
            count_next = 2'd0;
        end else begin
            count_next = count_reg + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= 32'h0;
            pc_write_reg  <= 1'b0;
        end else begin
            pc_write_reg <= do_issue || do_sentinel;
            case (state_reg)
                IDLE: begin
                    if (do_issue) begin
                        state_reg     <= WAIT;
                        imem_req_reg  <= 1'b1;
                        imem_addr_reg <= {bus.pc[31:2], 2'b00};
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        state_reg    <= IDLE;
                        imem_req_reg <= 1'b0;
                    end else if (bus.flush) begin
                        state_reg <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state_reg    <= IDLE;
                        imem_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    imem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            count_reg <= count_next;
            if (bus.flush) begin
                wr_ptr_reg <= 1'b0;
                rd_ptr_reg <= 1'b0;
            end else begin
                if (push) wr_ptr_reg <= ~wr_ptr_reg;
                if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // Storage holds no control state, so it needs no reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    instr_mem[gi] <= bus.imem_data;
                    pc_mem[gi]    <= imem_addr_reg;
                end
            end
        end
    endgenerate

    assign bus.pc_write  = pc_write_reg;
    assign bus.imem_req  = imem_req_reg;
    assign bus.imem_addr = imem_addr_reg;
    assign bus.valid     = (count_reg != 2'd0);
    assign bus.instr     = instr_mem[rd_ptr_reg];
    assign bus.instr_pc  = pc_mem[rd_ptr_reg];
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: PC register and memory models plus a decode-side scoreboard.
module tb_fetch_ctrl;
    localparam logic [31:0] SENT = 32'hFFFF_FFFF;
    localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    fetch_ctrl_if ifc ();

    fetch_ctrl dut (.clk(clk), .rst(rst), .bus(ifc.master));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    entry_t      sb[$];
    int          lat = 1;
    int          req_age = 0;
    int          ready_mode = 0;
    int          issues = 0;
    bit          discard = 1'b0;
    bit          prev_req, prev_pcw, prev_flush, prev_rst, prev_valid, prev_ready;
    int          prev_occ;
    logic [31:0] prev_pc, prev_addr, prev_instr, redirect_pc, last_issue_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // One clock cycle: account for the edge just passed, check outputs, then drive this cycle.
    task automatic cycle(input bit flush = 1'b0, input bit do_rst = 1'b0, input bit force_ack = 1'b0);
        int          occ_start;
        logic [31:0] exp_addr;
        entry_t      e;
        @(negedge clk);
        if (prev_rst) begin
            ifc.pc = SENT;
            check("rst_valid", ifc.valid, 0);
            check("rst_req", ifc.imem_req, 0);
            check("rst_addr", ifc.imem_addr, 0);
            check("rst_pcw", ifc.pc_write, 0);
            check("rst_misalign", ifc.misalign, 0);
        end else begin
            if (prev_flush)    ifc.pc = redirect_pc;
            else if (prev_pcw) ifc.pc = (ifc.pc == SENT) ? 32'h0 : ifc.pc + 32'd4;
            if (prev_pcw)   check("pcw_pulse", ifc.pc_write, 0);
            if (prev_flush) check("flush_pcw", ifc.pc_write, 0);
            if (ifc.imem_req && !prev_req) begin
                exp_addr = {prev_pc[31:2], 2'b00};
                check("issue_addr", ifc.imem_addr, exp_addr);
                check("issue_pcw", ifc.pc_write, 1);
                check("issue_room", prev_occ < 2, 1);
                last_issue_addr = ifc.imem_addr;
                issues++;
            end
            if (ifc.imem_req && prev_req) check("addr_stable", ifc.imem_addr, prev_addr);
            if (prev_valid && !prev_ready && !prev_flush) check("hold_instr", ifc.instr, prev_instr);
        end
        check("valid", ifc.valid, sb.size() != 0);
        occ_start = sb.size();

        case (ready_mode)
            0:       ifc.ready = 1'b0;
            1:       ifc.ready = 1'b1;
            default: ifc.ready = 1'($urandom_range(0, 1));
        endcase
        if (ifc.valid && ifc.ready && !flush && !do_rst && sb.size() > 0) begin
            e = sb.pop_front();
            check("pop_instr", ifc.instr, e.instr);
            check("pop_pc", ifc.instr_pc, e.pc);
        end

        ifc.imem_ack  = 1'b0;
        ifc.imem_data = 32'h0;
        if (do_rst) begin
            req_age = 0;
            discard = 1'b0;
        end else if (force_ack) begin
            ifc.imem_ack  = 1'b1;
            ifc.imem_data = BAD;
        end else if (ifc.imem_req) begin
            req_age++;
            if (req_age > lat) begin
                ifc.imem_ack = 1'b1;
                req_age      = 0;
                if (discard || flush) begin
                    ifc.imem_data = BAD;
                    discard       = 1'b0;
                end else begin
                    ifc.imem_data = data_of(ifc.imem_addr);
                    sb.push_back('{instr: ifc.imem_data, pc: ifc.imem_addr});
                end
            end else if (flush) begin
                discard = 1'b1;
            end
        end else begin
            req_age = 0;
        end
        if (flush || do_rst) sb.delete();
        ifc.flush = flush;
        rst       = do_rst;

        prev_rst   = do_rst;
        prev_flush = flush;
        prev_req   = ifc.imem_req;
        prev_pcw   = ifc.pc_write;
        prev_pc    = ifc.pc;
        prev_addr  = ifc.imem_addr;
        prev_occ   = occ_start;
        prev_valid = ifc.valid;
        prev_ready = ifc.ready;
        prev_instr = ifc.instr;
    endtask

    task automatic wait_issue(input string tag, input int max_cycles);
        int start;
        int n;
        start = issues;
        n = 0;
        while (issues == start && n < max_cycles) begin
            cycle();
            n++;
        end
        check(tag, issues != start, 1);
    endtask

    initial begin
        ifc.pc = SENT; ifc.imem_ack = 1'b0; ifc.imem_data = 32'h0;
        ifc.flush = 1'b0; ifc.ready = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        prev_rst = 1'b1;

        // Sentinel load then first fetch from 0
        cycle();
        cycle(); check("sent_pcw", ifc.pc_write, 1); check("sent_noreq", ifc.imem_req, 0);
        cycle(); check("sent_pcw_off", ifc.pc_write, 0);
        cycle();
        check("first_req", ifc.imem_req, 1);
        check("first_addr", ifc.imem_addr, 0);
        check("first_pcw", ifc.pc_write, 1);

        // Decode stalled: only two fetches buffered, third waits for a pop
        repeat (12) cycle();
        check("buf_valid", ifc.valid, 1);
        check("buf_head_pc", ifc.instr_pc, 0);
        check("buf_no_third", ifc.imem_req, 0);
        check("buf_issues", issues, 2);
        ready_mode = 1; cycle(); ready_mode = 0;
        cycle(); check("after_pop_head", ifc.instr_pc, 32'h4);
        wait_issue("third_issue", 6);
        check("third_addr", last_issue_addr, 32'h8);

        // Flush during a slow read: the dropped data never reaches decode
        ready_mode = 1;
        repeat (8) cycle();
        lat = 3;
        wait_issue("slow_issue", 20);
        redirect_pc = 32'h100;
        cycle(.flush(1'b1));
        cycle(); check("disc_req_held", ifc.imem_req, 1);
        cycle(); check("disc_ack", ifc.imem_ack, 1);
        cycle(); check("disc_valid", ifc.valid, 0); check("disc_req_off", ifc.imem_req, 0);
        wait_issue("redirect_issue", 6);
        check("redirect_addr", last_issue_addr, 32'h100);

        // Flush coincident with ack while one entry is buffered
        cycle(.do_rst(1'b1));
        ready_mode = 0; lat = 1;
        for (int i = 0; i < 30 && !(sb.size() == 1 && req_age == 1); i++) cycle();
        check("coinc_setup", (sb.size() == 1 && req_age == 1), 1);
        redirect_pc = 32'h200;
        cycle(.flush(1'b1));
        check("coinc_ack", ifc.imem_ack, 1);
        cycle();
        check("coinc_valid", ifc.valid, 0);
        check("coinc_req", ifc.imem_req, 0);
        check("coinc_pcw", ifc.pc_write, 0);
        wait_issue("coinc_issue", 6);
        check("coinc_addr", last_issue_addr, 32'h200);

        // Reset while a read is outstanding; the late ack is ignored
        ready_mode = 1; lat = 2;
        repeat (4) cycle();
        wait_issue("rst_wait_issue", 10);
        cycle(.do_rst(1'b1));
        cycle(.force_ack(1'b1));
        cycle();
        check("late_ack_valid", ifc.valid, 0);
        check("late_ack_req", ifc.imem_req, 0);
        check("late_ack_sent", ifc.pc_write, 1);
        cycle(); check("late_ack_valid2", ifc.valid, 0);

        // Misaligned redirect target
        lat = 1;
        wait_issue("mis_first", 10);
        redirect_pc = 32'h106;
        cycle(.flush(1'b1));
`ifdef FETCH_MISALIGN_CHK_EN
        repeat (6) begin
            cycle();
            check("mis_no_req", ifc.imem_req, 0);
            check("mis_no_pcw", ifc.pc_write, 0);
        end
        check("mis_flag", ifc.misalign, 1);
        cycle(.do_rst(1'b1));
        cycle(); check("mis_cleared", ifc.misalign, 0);
`else
        wait_issue("mis_issue", 6);
        check("mis_addr_forced", last_issue_addr, 32'h104);
        check("mis_flag_tied", ifc.misalign, 0);
`endif

        // Random traffic: decode back-pressure, varying latency, occasional redirects
        cycle(.do_rst(1'b1));
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 3);
            redirect_pc = 32'($urandom_range(0, 1023)) << 2;
            cycle(.flush($urandom_range(0, 15) == 0));
        end
        check("rand_progress", issues > 40, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
